// File: rtl/dec_pkg.sv
// dec_pkg: shared constants, ops-bundle field layout and skid-buffer state type for the decode select pipe.
package dec_pkg;
    localparam int DEF_OPS_W = 64;
    localparam int ALU_OFF = 0;
    localparam int ALU_W   = 24;
    localparam int IO_OFF  = 24;
    localparam int IO_W    = 16;
    localparam int BJ_OFF  = 40;
    localparam int BJ_W    = 16;
    localparam int SYS_OFF = 56;
    localparam int SYS_W   = 8;
    localparam int SEL_C16 = 0;
    localparam int SEL_I32 = 1;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: generic 2-entry skid buffer with registered in_ready and flush.
module dec_skid_buf
    import dec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    buf_state_t state, state_nx;
    logic [W-1:0] skid;
    logic acc, drn, ld_main_in, ld_main_skid, ld_skid;

    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;
    assign out_valid = state != EMPTY;

    always_comb begin
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: if (acc) begin
                state_nx   = ONE;
                ld_main_in = 1'b1;
            end
            ONE: if (acc && drn) ld_main_in = 1'b1;
                 else if (acc) begin
                     state_nx = FULL;
                     ld_skid  = 1'b1;
                 end
                 else if (drn) state_nx = EMPTY;
            FULL: if (drn) begin
                state_nx     = ONE;
                ld_main_skid = 1'b1;
            end
            default: state_nx = EMPTY;
        endcase
        // a flush drops the incoming word and anything buffered; data regs keep stale contents
        if (flush) begin
            state_nx     = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            out_data <= '0;
            skid     <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != FULL;
            if (ld_main_in) out_data <= in_data;
            else if (ld_main_skid) out_data <= skid;
            if (ld_skid) skid <= in_data;
        end
    end
endmodule

// File: rtl/dec_sel_pipe.sv
// dec_sel_pipe: selects one of N_SRC decoder ops bundles by index and registers it with the PC through a skid buffer.
// Optional DEC_SEL_PIPE_PERF_EN adds saturating stall / compressed-accept counters.
module dec_sel_pipe
    import dec_pkg::*;
#(
    parameter  int N_SRC = 2,
    parameter  int OPS_W = DEF_OPS_W,
    parameter  int XLEN  = 64,
    localparam int SEL_W = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [N_SRC*OPS_W-1:0] src_ops,
    input  logic [XLEN-1:0]        src_pc,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [OPS_W-1:0]       id_ops,
    output logic [XLEN-1:0]        id_pc,
    output logic [SEL_W-1:0]       id_sel,
    output logic                   id_illegal
`ifdef DEC_SEL_PIPE_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_cmp_cnt
`endif
);
    localparam int PW = 1 + SEL_W + XLEN + OPS_W;

    logic [OPS_W-1:0] sel_ops;
    logic             illegal;

    // out-of-range indices (only possible for non power-of-2 N_SRC) yield a zero bundle
    always_comb begin
        sel_ops = '0;
        for (int i = 0; i < N_SRC; i++)
            if (src_sel == SEL_W'(i)) sel_ops = src_ops[i*OPS_W +: OPS_W];
    end

    assign illegal = 32'(src_sel) >= N_SRC;

    dec_skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (src_valid),
        .in_ready  (src_ready),
        .in_data   ({illegal, src_sel, src_pc, sel_ops}),
        .out_valid (id_valid),
        .out_ready (id_ready),
        .out_data  ({id_illegal, id_sel, id_pc, id_ops})
    );

`ifdef DEC_SEL_PIPE_PERF_EN
    logic acc;
    assign acc = src_valid & src_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
            perf_cmp_cnt   <= '0;
        end else begin
            if (id_valid && !id_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (acc && src_sel == SEL_W'(SEL_C16) && perf_cmp_cnt != '1) perf_cmp_cnt <= perf_cmp_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dec_sel_pipe.sv
// tb_dec_sel_pipe: directed table-driven bench for dec_sel_pipe (N_SRC=3) plus handshake/flush/reset sequences.
module tb_dec_sel_pipe;
    localparam int N  = 3;
    localparam int OW = 64;
    localparam int XL = 64;
    localparam int SW = 2;

    logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, src_valid = 1'b0, id_ready = 1'b0;
    logic src_ready, id_valid, id_illegal;
    logic [SW-1:0] src_sel = '0, id_sel;
    logic [N*OW-1:0] src_ops = '0;
    logic [XL-1:0] src_pc = '0, id_pc;
    logic [OW-1:0] id_ops;
`ifdef DEC_SEL_PIPE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_cmp_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_sel_pipe #(.N_SRC(N), .OPS_W(OW), .XLEN(XL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_sel    (src_sel),
        .src_ops    (src_ops),
        .src_pc     (src_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_ops     (id_ops),
        .id_pc      (id_pc),
        .id_sel     (id_sel),
        .id_illegal (id_illegal)
`ifdef DEC_SEL_PIPE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_cmp_cnt   (perf_cmp_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] s0, s1, s2;
        logic [63:0] pc;
        logic [63:0] eops;
        logic        eill;
    } vec_t;

    vec_t v[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        v[0] = '{2'd1, 64'h5555, 64'hAAAA, 64'h1234, 64'h8000_0000, 64'hAAAA, 1'b0};
        v[1] = '{2'd0, 64'h5555, 64'hAAAA, 64'h1234, 64'h8000_0002, 64'h5555, 1'b0};
        v[2] = '{2'd2, 64'h5555, 64'hAAAA, 64'h1234, 64'h8000_0006, 64'h1234, 1'b0};
        v[3] = '{2'd3, 64'hFFFF, 64'hEEEE, 64'hDDDD, 64'h8000_000A, 64'h0,    1'b1};
        v[4] = '{2'd1, 64'h1, 64'hDEAD_BEEF_CAFE_F00D, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_src_ready", 128'(src_ready), 128'd1);
        chk("rst_id_valid", 128'(id_valid), 128'd0);
        chk("rst_id_ops", 128'(id_ops), 128'd0);
        chk("rst_id_pc", 128'(id_pc), 128'd0);
        chk("rst_id_sel", 128'(id_sel), 128'd0);
        chk("rst_id_illegal", 128'(id_illegal), 128'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            src_valid = 1'b1;
            src_sel   = v[i].sel;
            src_ops   = {v[i].s2, v[i].s1, v[i].s0};
            src_pc    = v[i].pc;
            id_ready  = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), 128'(id_valid), 128'd1);
            chk($sformatf("vec%0d_ops", i), 128'(id_ops), 128'(v[i].eops));
            chk($sformatf("vec%0d_pc", i), 128'(id_pc), 128'(v[i].pc));
            chk($sformatf("vec%0d_sel", i), 128'(id_sel), 128'(v[i].sel));
            chk($sformatf("vec%0d_illegal", i), 128'(id_illegal), 128'(v[i].eill));
            src_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_drained", i), 128'(id_valid), 128'd0);
        end

        src_sel = 2'd1;
        id_ready = 1'b0;
        src_valid = 1'b1;
        src_pc = 64'h0;
        step();
        chk("bp1_valid", 128'(id_valid), 128'd1);
        chk("bp1_pc", 128'(id_pc), 128'h0);
        chk("bp1_src_ready", 128'(src_ready), 128'd1);
        src_pc = 64'h2;
        step();
        chk("bp2_src_ready", 128'(src_ready), 128'd0);
        chk("bp2_pc", 128'(id_pc), 128'h0);
        src_pc = 64'h6;
        step();
        chk("bp3_src_ready", 128'(src_ready), 128'd0);
        chk("bp3_hold_pc", 128'(id_pc), 128'h0);
        chk("bp3_valid", 128'(id_valid), 128'd1);
        id_ready = 1'b1;
        step();
        chk("bp4_pc", 128'(id_pc), 128'h2);
        chk("bp4_src_ready", 128'(src_ready), 128'd1);
        step();
        chk("bp5_pc", 128'(id_pc), 128'h6);
        src_valid = 1'b0;
        step();
        chk("bp6_empty", 128'(id_valid), 128'd0);

        for (int i = 0; i < 100; i++) begin
            src_valid = 1'b1;
            src_pc = 64'h1000 + 64'(4 * i);
            src_sel = 2'(i % 2);
            step();
            chk($sformatf("stream%0d", i), {id_valid, src_ready, id_pc}, {1'b1, 1'b1, 64'h1000 + 64'(4 * i)});
        end
        src_valid = 1'b0;
        step();
        chk("stream_end", 128'(id_valid), 128'd0);

        id_ready = 1'b0;
        src_valid = 1'b1;
        src_pc = 64'h100;
        step();
        src_pc = 64'h104;
        step();
        chk("fl_full_src_ready", 128'(src_ready), 128'd0);
        flush = 1'b1;
        src_pc = 64'h108;
        step();
        flush = 1'b0;
        src_valid = 1'b0;
        chk("fl_full_valid", 128'(id_valid), 128'd0);
        chk("fl_full_src_ready2", 128'(src_ready), 128'd1);
        step();
        chk("fl_full_after", 128'(id_valid), 128'd0);
        src_valid = 1'b1;
        src_pc = 64'h200;
        step();
        flush = 1'b1;
        src_pc = 64'h204;
        step();
        flush = 1'b0;
        src_valid = 1'b0;
        chk("fl_one_valid", 128'(id_valid), 128'd0);
        step();
        chk("fl_one_discard", 128'(id_valid), 128'd0);
        id_ready = 1'b1;
        src_valid = 1'b1;
        src_pc = 64'h300;
        step();
        chk("fl_resume_pc", 128'(id_pc), 128'h300);
        chk("fl_resume_valid", 128'(id_valid), 128'd1);
        src_valid = 1'b0;
        step();

        id_ready = 1'b0;
        src_valid = 1'b1;
        src_sel = 2'd0;
        src_pc = 64'h400;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 128'(id_valid), 128'd0);
        chk("arst_src_ready", 128'(src_ready), 128'd1);
        chk("arst_pc", 128'(id_pc), 128'h0);
`ifdef DEC_SEL_PIPE_PERF_EN
        chk("arst_stall_cnt", 128'(perf_stall_cnt), 128'd0);
        chk("arst_cmp_cnt", 128'(perf_cmp_cnt), 128'd0);
`endif
        src_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("arst_release_valid", 128'(id_valid), 128'd0);

`ifdef DEC_SEL_PIPE_PERF_EN
        id_ready = 1'b1;
        src_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1;
            src_pc = 64'h500 + 64'(i);
            step();
        end
        src_valid = 1'b0;
        id_ready = 1'b0;
        repeat (5) step();
        chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'd5);
        chk("perf_cmp_cnt", 128'(perf_cmp_cnt), 128'd4);
        id_ready = 1'b1;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_sel_pipe.md
Name: dec_sel_pipe

Overview:
Parametrised, registered successor to the compressed/32-bit decode select. Takes N_SRC parallel decoder outputs, each a packed ops bundle of OPS_W bits (alu/io/bj/sys ops concatenated), and selects one per instruction by index. Registers the selected bundle plus PC into a 2-entry skid buffer with valid/ready handshakes on both sides. Sits between the decoder bank and the issue/execute stage; handles back-pressure and pipeline flush.

Parameters:
N_SRC, 2, number of decoder sources (0 = compressed, 1 = 32-bit, 2+ = extensions); minimum 2.
OPS_W, 64, width of one packed ops bundle.
XLEN, 64, PC width.
SEL_W, $clog2(N_SRC), source index width (derived; not overridable).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered and incoming entries
src_valid  in  1  upstream has an instruction
src_ready  out  1  block can accept (registered)
src_sel  in  SEL_W  decoder index for this instruction
src_ops  in  N_SRC*OPS_W  all decoder bundles; source i at [i*OPS_W +: OPS_W]
src_pc  in  XLEN  instruction PC
id_valid  out  1  output entry valid
id_ready  in  1  downstream accepts
id_ops  out  OPS_W  selected bundle
id_pc  out  XLEN  PC of output entry
id_sel  out  SEL_W  source index of output entry
id_illegal  out  1  src_sel was >= N_SRC

Behaviour:
- Reset values: src_ready=1, id_valid=0, id_ops=0, id_pc=0, id_sel=0, id_illegal=0, skid entry invalid.
- Accept = src_valid & src_ready; drain = id_valid & id_ready.
- Select: combinational mux on src_sel before capture. src_sel >= N_SRC (non-power-of-2 N_SRC) captures ops=0, illegal=1.
- Storage: main register (drives id_*) and skid register. States: EMPTY, ONE (main valid), FULL (main+skid valid).
- EMPTY: accept -> ONE, capture into main; latency 1 cycle src->id.
- ONE: accept & drain -> ONE, new data into main; accept & !drain -> FULL, new data into skid; drain only -> EMPTY; neither -> hold.
- FULL: src_ready=0; drain -> ONE, skid moves to main; else hold.
- src_ready = !(state==FULL), registered; no combinational path id_ready->src_ready.
- Output stable: while id_valid & !id_ready, id_ops/pc/sel/illegal must not change.
- Order preserved; no entry dropped or duplicated except by flush.
- flush: next state EMPTY, id_valid=0, skid cleared; a same-cycle accept is discarded; a same-cycle drain is still counted as consumed by downstream. Data registers need not clear on flush.
- Reset asserted mid-operation: all state returns to reset values asynchronously; no output glitch on release.

Optional Feature:
DEC_SEL_PIPE_PERF_EN: adds outputs perf_stall_cnt (32) and perf_cmp_cnt (32). perf_stall_cnt increments each cycle id_valid & !id_ready. perf_cmp_cnt increments per accepted entry with src_sel==0. Both saturate at 32'hFFFF_FFFF, reset to 0, are unaffected by flush. Without the macro, neither port nor counter exists.

Decomposition:
- Package dec_pkg: OPS_W default, per-group field offsets/widths (alu, io, bj, sys), SEL constants SEL_C16=0, SEL_I32=1, state enum {EMPTY, ONE, FULL}.
- Sub-module dec_skid_buf (generic 2-entry skid buffer, payload width parameter) instantiated once; the select mux stays in dec_sel_pipe.

Test Plan:
- Single transfer: N_SRC=2, src_sel=1, src_ops={64'hAAAA, 64'h5555}, pc=0x8000_0000, id_ready=1 -> next cycle id_valid=1, id_ops=64'hAAAA, id_sel=1, id_illegal=0.
- Back-pressure: id_ready=0, send 3 back-to-back -> entries 1,2 held, src_ready=0 after 2nd accept, 3rd not accepted. Raise id_ready -> output PCs in order 0x0, 0x2, 0x6, no loss.
- Streaming: id_ready=1, src_valid=1 for 100 cycles -> 100 outputs, throughput 1/cycle, src_ready never drops.
- Flush in FULL with src_valid=1 -> next cycle id_valid=0, src_ready=1, flushed-cycle input never appears.
- Illegal index: N_SRC=3, src_sel=3 -> id_ops=0, id_illegal=1.
- With DEC_SEL_PIPE_PERF_EN: 5 stall cycles and 4 accepts with sel=0 -> perf_stall_cnt=5, perf_cmp_cnt=4. Asserting reset_n=0 mid-stream clears both counters and id_valid immediately.
